decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised, pipelined instruction-decode stage with an ID/EX output register. It reads two operands from an internal register file (with an optional write-back bypass), sign-extends and scales the immediate, and resolves branches using four compare modes. It detects load-use hazards, supports stall and flush, and sits between the fetch stage (valid/ready handshake) and the execute stage.

## Interface
- XLEN, 32, datapath and register width
- NREG, 16, register count; AW = $clog2(NREG)
- IMM_W, 19, raw immediate width (IMM_W ≤ XLEN-2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- ra, rb, rd  in  AW  source A, source B, destination
- imm  in  IMM_W  raw immediate
- branch  in  1  instruction is a conditional branch
- cmp_op  in  2  00 EQ, 01 NE, 10 LT signed, 11 GE signed
- is_load  in  1  instruction loads rd from memory
- wb_en  in  1  write-back enable
- wb_addr  in  AW  write-back register
- wb_data  in  XLEN  write-back value
- ex_stall  in  1  execute cannot accept; hold output
- flush  in  1  kill the instruction in decode and in the ID/EX register
- out_valid  out  1  ID/EX register holds a live instruction
- out_a, out_b  out  XLEN  operand data
- out_imm  out  XLEN  sign-extended imm
- out_boff  out  XLEN  branch offset = out_imm << 2
- out_rd  out  AW  destination
- out_is_load  out  1  registered is_load
- pc_select  out  1  branch taken (registered, qualified by out_valid)

## Operation
- Register file: NREG×XLEN. Two combinational reads (ra, rb), one write on clk when wb_en=1. Every register is writable; there is no hard-zero register.
- Hazard: `haz = in_valid & out_valid & out_is_load & (out_rd==ra | out_rd==rb)`.
- `in_ready = !ex_stall & !haz`. The flush override below takes precedence.
- Per-edge priority for the ID/EX register:
  - rst: clear all outputs.
  - flush: load a bubble.
  - ex_stall: hold.
  - haz: load a bubble.
  - in_valid & in_ready: load the instruction.
  - Otherwise: load a bubble.
- A bubble sets out_valid=0, pc_select=0 and out_is_load=0. Data fields may keep stale values but are zeroed on rst.
- When flush=1, in_ready=1, and any presented instruction is consumed and discarded.
- Compare uses the post-bypass operands.
  - EQ/NE: bitwise.
  - LT/GE: signed over XLEN.
- `pc_select <= branch & cmp_true` on instruction load.
- Immediate: sign-extend imm[IMM_W-1] to XLEN. out_boff is the arithmetic left shift by 2, truncated to XLEN.
- Write-back proceeds during stall, flush and hazard cycles.
- A stalled instruction's operands are not re-read; the values latched at acceptance stand.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N.
- Throughput is 1 instruction/cycle absent stall or hazard.
- A load-use hazard costs exactly one bubble.
  - The load is in ID/EX at edge N. The dependent instruction is held (in_ready=0) for that cycle and is accepted at edge N+1.
- Reset values:
  - Register file: all entries 0.
  - out_valid, pc_select, out_is_load: 0.
  - out_a, out_b, out_imm, out_boff: 0.
  - out_rd: 0.
- Reset mid-stream discards any in-flight instruction. in_ready is combinational and is 1 during reset when ex_stall=0.
- Same-cycle write-back and read of the same address: see Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined: if wb_en & wb_addr==ra (or rb) in the acceptance cycle, the operand and the compare use wb_data.
- DECODE_WB_BYPASS_EN undefined: reads return the pre-write value. The new value is visible from the next cycle.

## Structure
- Package decode_pkg holds:
  - cmp_op_e enum (CMP_EQ, CMP_NE, CMP_LT, CMP_GE).
  - Default XLEN/NREG/IMM_W localparams.
  - Packed struct id_ex_t (valid, a, b, imm, rd, is_load, pc_sel).
- Sub-module decode_regfile (parametrised XLEN/NREG) holds the storage, the synchronous reset and the macro-controlled bypass.
- decode_stage holds the hazard logic, compare logic, immediate logic and the ID/EX register.

## Test plan
- Reset:
  - Assert rst for 2 cycles with in_valid=1, then release.
  - Required: out_valid=0, pc_select=0, and all registers read 0.
- Branch compare:
  - Write R3=-5 and R4=2. Issue branch cmp_op=LT with ra=3, rb=4.
  - Required: pc_select=1 one cycle later. Repeat with GE: pc_select=0.
- Immediate:
  - imm=19'h7FFFF → out_imm=32'hFFFFFFFF, out_boff=32'hFFFFFFFC.
  - imm=19'h00010 → out_boff=32'h40.
- Load-use:
  - Issue a load with rd=5, then an instruction with ra=5.
  - Required: in_ready=0 for one cycle, one out_valid=0 bubble, then the dependent instruction appears.
- Stall/flush:
  - Hold ex_stall=1 for 3 cycles → outputs stay frozen.
  - Then assert flush with ex_stall still 1 → out_valid=0 at the next edge.
- Bypass:
  - In one cycle set wb_en=1, wb_addr=7, wb_data=0x1234, and accept an instruction with ra=7.
  - Required: out_a=0x1234 with DECODE_WB_BYPASS_EN defined, and the old value (0) without it.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and default sizes for the decode stage
package decode_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREG  = 16;
   localparam int DEF_IMM_W = 19;

   typedef enum logic [1:0] {
      CMP_EQ = 2'b00,
      CMP_NE = 2'b01,
      CMP_LT = 2'b10,
      CMP_GE = 2'b11
   } cmp_op_e;

   typedef struct packed {
      logic                         valid;
      logic [DEF_XLEN-1:0]          a;
      logic [DEF_XLEN-1:0]          b;
      logic [DEF_XLEN-1:0]          imm;
      logic [$clog2(DEF_NREG)-1:0]  rd;
      logic                         is_load;
      logic                         pc_sel;
   } id_ex_t;

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - NREG x XLEN register file, two async reads, one write
// DECODE_WB_BYPASS_EN forwards a same-cycle write-back onto the read ports.
module decode_regfile
   import decode_pkg::*;
#(
   parameter  int XLEN = DEF_XLEN,
   parameter  int NREG = DEF_NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra,
   input  logic [AW-1:0]   rb,
   output logic [XLEN-1:0] data_a,
   output logic [XLEN-1:0] data_b,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en) begin
         regs[wb_addr] <= wb_data;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   assign data_a = (wb_en && (wb_addr == ra)) ? wb_data : regs[ra];
   assign data_b = (wb_en && (wb_addr == rb)) ? wb_data : regs[rb];
`else
   // Without the bypass the write lands at the edge, so readers see the old value.
   assign data_a = regs[ra];
   assign data_b = regs[rb];
`endif

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode with hazard detect, branch compare and ID/EX register
// Same-cycle write-back forwarding is selected by DECODE_WB_BYPASS_EN (in decode_regfile).
module decode_stage
   import decode_pkg::*;
#(
   parameter  int XLEN  = DEF_XLEN,
   parameter  int NREG  = DEF_NREG,
   parameter  int IMM_W = DEF_IMM_W,
   localparam int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic [AW-1:0]    rd,
   input  logic [IMM_W-1:0] imm,
   input  logic             branch,
   input  logic [1:0]       cmp_op,
   input  logic             is_load,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             ex_stall,
   input  logic             flush,
   output logic             out_valid,
   output logic [XLEN-1:0]  out_a,
   output logic [XLEN-1:0]  out_b,
   output logic [XLEN-1:0]  out_imm,
   output logic [XLEN-1:0]  out_boff,
   output logic [AW-1:0]    out_rd,
   output logic             out_is_load,
   output logic             pc_select
);

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] imm_ext;
   logic            haz;
   logic            cmp_true;

   decode_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .ra      (ra),
      .rb      (rb),
      .data_a  (op_a),
      .data_b  (op_b),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data)
   );

   assign haz      = in_valid & out_valid & out_is_load & ((out_rd == ra) | (out_rd == rb));
   // A flush swallows whatever fetch presents, so it always looks accepted.
   assign in_ready = flush | (~ex_stall & ~haz);

   assign imm_ext  = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   assign out_boff = {out_imm[XLEN-3:0], 2'b00};

   always_comb begin
      cmp_true = 1'b0;
      case (cmp_op_e'(cmp_op))
         CMP_EQ:  cmp_true = (op_a == op_b);
         CMP_NE:  cmp_true = (op_a != op_b);
         CMP_LT:  cmp_true = ($signed(op_a) <  $signed(op_b));
         CMP_GE:  cmp_true = ($signed(op_a) >= $signed(op_b));
         default: cmp_true = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         pc_select   <= 1'b0;
         out_is_load <= 1'b0;
         out_a       <= '0;
         out_b       <= '0;
         out_imm     <= '0;
         out_rd      <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         pc_select   <= 1'b0;
         out_is_load <= 1'b0;
      end else if (ex_stall) begin
         out_valid   <= out_valid;
      end else if (haz || !in_valid) begin
         out_valid   <= 1'b0;
         pc_select   <= 1'b0;
         out_is_load <= 1'b0;
      end else begin
         out_valid   <= 1'b1;
         out_a       <= op_a;
         out_b       <= op_b;
         out_imm     <= imm_ext;
         out_rd      <= rd;
         out_is_load <= is_load;
         pc_select   <= branch & cmp_true;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized bench with behavioural model for decode_stage
// Honours DECODE_WB_BYPASS_EN the same way the design does.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ra, rb, rd;
   logic [18:0] imm;
   logic        branch;
   logic [1:0]  cmp_op;
   logic        is_load;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        ex_stall;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_a, out_b, out_imm, out_boff;
   logic [3:0]  out_rd;
   logic        out_is_load;
   logic        pc_select;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ra          (ra),
      .rb          (rb),
      .rd          (rd),
      .imm         (imm),
      .branch      (branch),
      .cmp_op      (cmp_op),
      .is_load     (is_load),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ex_stall    (ex_stall),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_imm     (out_imm),
      .out_boff    (out_boff),
      .out_rd      (out_rd),
      .out_is_load (out_is_load),
      .pc_select   (pc_select)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [31:0] m_reg [16];
   bit          m_valid, m_pc, m_load;
   logic [31:0] m_a, m_b, m_imm, m_boff;
   logic [3:0]  m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_haz();
      return in_valid && m_valid && m_load && (m_rd == ra || m_rd == rb);
   endfunction

   function automatic bit m_ready();
      return flush || (!ex_stall && !m_haz());
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] adr);
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && wb_addr == adr) return wb_data;
`endif
      return m_reg[adr];
   endfunction

   function automatic logic [31:0] sext(input logic [18:0] v);
      int t;
      t = int'(v);
      if (t >= 262144) t = t - 524288;
      return t;
   endfunction

   function automatic bit taken(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'd0:    return a == b;
         2'd1:    return a != b;
         2'd2:    return int'(a) < int'(b);
         default: return int'(a) >= int'(b);
      endcase
   endfunction

   task automatic cycle();
      logic [31:0] na, nb;
      bit          h;
      na = m_read(ra);
      nb = m_read(rb);
      h  = m_haz();
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_pc = 0; m_load = 0;
         m_a = 0; m_b = 0; m_imm = 0; m_boff = 0; m_rd = 0;
         for (int i = 0; i < 16; i++) m_reg[i] = 0;
      end else begin
         if (wb_en) m_reg[wb_addr] = wb_data;
         if (flush) begin
            m_valid = 0; m_pc = 0; m_load = 0;
         end else if (ex_stall) begin
            m_valid = m_valid;
         end else if (h || !in_valid) begin
            m_valid = 0; m_pc = 0; m_load = 0;
         end else begin
            m_valid = 1;
            m_a     = na;
            m_b     = nb;
            m_imm   = sext(imm);
            m_boff  = m_imm * 4;
            m_rd    = rd;
            m_load  = is_load;
            m_pc    = branch && taken(cmp_op, na, nb);
         end
      end
      chk_en = 1'b1;
      #1;
   endtask

   task automatic idle();
      rst = 0; in_valid = 0; ra = 0; rb = 0; rd = 0; imm = 0; branch = 0;
      cmp_op = 0; is_load = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
      ex_stall = 0; flush = 0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", in_ready, m_ready());
         chk("out_valid", out_valid, m_valid);
         chk("pc_select", pc_select, m_pc);
         chk("out_is_load", out_is_load, m_load);
         if (m_valid) begin
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_imm", out_imm, m_imm);
            chk("out_boff", out_boff, m_boff);
            chk("out_rd", out_rd, m_rd);
         end
      end
   end

   initial begin
      m_valid = 0; m_pc = 0; m_load = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_boff = 0; m_rd = 0;
      for (int i = 0; i < 16; i++) m_reg[i] = 0;

      idle();
      rst = 1; in_valid = 1; ra = 1; rb = 2;
      cycle();
      cycle();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_pc_select", pc_select, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_boff", out_boff, 0);
      chk("rst_in_ready", in_ready, 1);

      rst = 0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1; ra = 4'(i); rb = 4'(15 - i); rd = 4'(i);
         cycle();
         chk("rf_zero_a", out_a, 0);
         chk("rf_zero_b", out_b, 0);
      end

      idle();
      wb_en = 1; wb_addr = 3; wb_data = 32'hFFFF_FFFB;
      cycle();
      wb_addr = 4; wb_data = 32'd2;
      cycle();
      idle();
      in_valid = 1; branch = 1; cmp_op = 2'b10; ra = 3; rb = 4;
      cycle();
      chk("branch_lt_taken", pc_select, 1);
      cmp_op = 2'b11;
      cycle();
      chk("branch_ge_not_taken", pc_select, 0);

      branch = 0; imm = 19'h7FFFF;
      cycle();
      chk("imm_neg", out_imm, 32'hFFFF_FFFF);
      chk("boff_neg", out_boff, 32'hFFFF_FFFC);
      imm = 19'h00010;
      cycle();
      chk("boff_pos", out_boff, 32'h0000_0040);

      idle();
      in_valid = 1; is_load = 1; rd = 5;
      cycle();
      chk("lu_load_issued", out_is_load, 1);
      is_load = 0; rd = 6; ra = 5; rb = 1;
      #1;
      chk("lu_in_ready_low", in_ready, 0);
      cycle();
      chk("lu_bubble", out_valid, 0);
      chk("lu_in_ready_back", in_ready, 1);
      cycle();
      chk("lu_dependent_valid", out_valid, 1);
      chk("lu_dependent_rd", out_rd, 6);

      idle();
      wb_en = 1; wb_addr = 9; wb_data = 32'h0000_ABCD;
      cycle();
      idle();
      in_valid = 1; ra = 9; rb = 9; rd = 2;
      cycle();
      chk("stall_pre_a", out_a, 32'h0000_ABCD);
      ex_stall = 1;
      repeat (3) begin
         ra = 4'($urandom_range(0, 15));
         imm = 19'($urandom);
         cycle();
         chk("stall_hold_a", out_a, 32'h0000_ABCD);
         chk("stall_hold_valid", out_valid, 1);
      end
      flush = 1;
      cycle();
      chk("flush_under_stall", out_valid, 0);

      idle();
      wb_en = 1; wb_addr = 7; wb_data = 32'h0000_1234; in_valid = 1; ra = 7;
      cycle();
`ifdef DECODE_WB_BYPASS_EN
      chk("bypass_a", out_a, 32'h0000_1234);
`else
      chk("no_bypass_a", out_a, 32'h0000_0000);
`endif

      repeat (3000) begin
         rst      = ($urandom_range(0, 99) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         ra       = 4'($urandom_range(0, 7));
         rb       = 4'($urandom_range(0, 7));
         rd       = 4'($urandom_range(0, 7));
         imm      = 19'($urandom);
         branch   = ($urandom_range(0, 1) == 1);
         cmp_op   = 2'($urandom);
         is_load  = ($urandom_range(0, 2) == 0);
         wb_en    = ($urandom_range(0, 1) == 1);
         wb_addr  = 4'($urandom_range(0, 7));
         wb_data  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
         ex_stall = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         cycle();
      end

      idle();
      cycle();
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
